// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, direction and error enums, and
// decode helpers shared by the traffic light monitor files.
package traffic_pkg;

    localparam logic [3:0] LT_RED     = 4'b0001;
    localparam logic [3:0] LT_YEL     = 4'b0010;
    localparam logic [3:0] LT_GRN     = 4'b0100;
    localparam logic [3:0] LT_GRN_ARW = 4'b1100;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_CODE     = 3'd1,
        ERR_CONFLICT = 3'd2,
        ERR_SEQ      = 3'd3,
        ERR_TIMING   = 3'd4,
        ERR_STALL    = 3'd5
    } err_t;

    // Green and green+arrow collapse to one state: swapping
    // between them is always legal.
    typedef enum logic [1:0] {
        ST_RED = 2'd0,
        ST_YEL = 2'd1,
        ST_GRN = 2'd2
    } lst_t;

    // Illegal codes decode to red.
    function automatic lst_t decode_light(input logic [3:0] code);
        lst_t st;
        case (code)
            LT_YEL:             st = ST_YEL;
            LT_GRN, LT_GRN_ARW: st = ST_GRN;
            default:            st = ST_RED;
        endcase
        return st;
    endfunction

    function automatic logic is_legal_code(input logic [3:0] code);
        return (code == LT_RED) || (code == LT_YEL) ||
               (code == LT_GRN) || (code == LT_GRN_ARW);
    endfunction

    // Lowest set bit wins: N > E > S > W.
    function automatic dir_t first_dir(input logic [3:0] v);
        dir_t d;
        d = DIR_N;
        if (v[0])      d = DIR_N;
        else if (v[1]) d = DIR_E;
        else if (v[2]) d = DIR_S;
        else if (v[3]) d = DIR_W;
        return d;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_dir.sv
// light_dir_checker: one direction's decode, prev/cur sample
// registers, transition check and yellow-duration timer.
// Ports: clk, rst_n, i_code (4b light code);
//        o_illegal, o_seq_err, o_timing_err, o_is_active,
//        o_phase_done (per-cycle, from the cur/prev pair).
module light_dir_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_YELLOW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_code,
    output logic       o_illegal,
    output logic       o_seq_err,
    output logic       o_timing_err,
    output logic       o_is_active,
    output logic       o_phase_done
);

    localparam int YC_W = $clog2(MAX_YELLOW + 2);
    localparam logic [YC_W-1:0] YC_SAT = YC_W'(MAX_YELLOW + 1);
    localparam logic [YC_W-1:0] YC_MIN = YC_W'(MIN_YELLOW);
    localparam logic [YC_W-1:0] YC_ONE = YC_W'(1);

    lst_t            r_cur;
    lst_t            r_prev;
    logic            r_cur_ill;
    // Length of the yellow run ending at the prev sample.
    logic [YC_W-1:0] r_ycnt;

    logic [YC_W-1:0] w_ycnt;
    logic            w_y2r;
    logic            w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur     <= ST_RED;
            r_prev    <= ST_RED;
            r_cur_ill <= 1'b0;
            r_ycnt    <= '0;
        end else begin
            r_cur     <= decode_light(i_code);
            r_cur_ill <= !is_legal_code(i_code);
            r_prev    <= r_cur;
            r_ycnt    <= w_ycnt;
        end
    end

    // Yellow run length including the cur sample, saturating.
    always_comb begin
        w_ycnt = '0;
        if (r_cur == ST_YEL) begin
            if (r_prev != ST_YEL)
                w_ycnt = YC_ONE;
            else if (r_ycnt == YC_SAT)
                w_ycnt = YC_SAT;
            else
                w_ycnt = r_ycnt + YC_ONE;
        end
    end

    assign w_y2r = (r_prev == ST_YEL) && (r_cur == ST_RED);

    assign w_legal = (r_prev == r_cur) ||
                     (r_prev == ST_RED && r_cur == ST_GRN) ||
                     (r_prev == ST_GRN && r_cur == ST_YEL) ||
                     w_y2r;

    assign o_illegal    = r_cur_ill;
    assign o_seq_err    = !w_legal;
    assign o_is_active  = (r_cur != ST_RED);
    assign o_phase_done = w_y2r;

    // Overlong fires only on the step into saturation, so a
    // single long yellow reports once.
    assign o_timing_err = (w_y2r && (r_ycnt < YC_MIN)) ||
                          ((w_ycnt == YC_SAT) &&
                           (r_ycnt != YC_SAT));

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker of the four light codes.
// Ports: clk, rst_n, north/east/south/west (4b codes), clr_err;
//        err_* sticky flags, first_err_type/dir capture,
//        active_valid/active_dir, phase_count (saturating).
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW  = 3,
    parameter int MAX_YELLOW  = 8,
    parameter int MAX_ALL_RED = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       north,
    input  logic [3:0]       east,
    input  logic [3:0]       south,
    input  logic [3:0]       west,
    input  logic             clr_err,
    output logic             err_code,
    output logic             err_conflict,
    output logic             err_seq,
    output logic             err_timing,
    output logic             err_stall,
    output logic [2:0]       first_err_type,
    output logic [1:0]       first_err_dir,
    output logic             active_valid,
    output logic [1:0]       active_dir,
    output logic [CNT_W-1:0] phase_count
);

    localparam int RC_W = $clog2(MAX_ALL_RED + 2);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_ALL_RED);
    localparam logic [RC_W-1:0] RC_SAT = RC_W'(MAX_ALL_RED + 1);
    localparam logic [RC_W-1:0] RC_ONE = RC_W'(1);
    localparam logic [CNT_W:0]  PC_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [3:0]       w_code [4];
    logic [3:0]       w_ill;
    logic [3:0]       w_seq;
    logic [3:0]       w_tim;
    logic [3:0]       w_act;
    logic [3:0]       w_pd;

    logic [2:0]       w_nact;
    logic [2:0]       w_npd;
    logic             w_all_red;
    logic             w_conflict;
    logic             w_stall;
    err_t             w_new_type;
    dir_t             w_new_dir;
    err_t             w_base;
    logic [CNT_W:0]   w_pc_sum;

    // cur holds a real sample (not the reset value).
    logic             r_vld;
    logic [RC_W-1:0]  r_red_cnt;
    logic             r_err_code;
    logic             r_err_conflict;
    logic             r_err_seq;
    logic             r_err_timing;
    logic             r_err_stall;
    err_t             r_first_type;
    dir_t             r_first_dir;
    logic             r_act_vld;
    dir_t             r_act_dir;
    logic [CNT_W-1:0] r_pc;

    assign w_code[0] = north;
    assign w_code[1] = east;
    assign w_code[2] = south;
    assign w_code[3] = west;

    for (genvar g = 0; g < 4; g++) begin : g_dir
        light_dir_checker #(
            .MIN_YELLOW (MIN_YELLOW),
            .MAX_YELLOW (MAX_YELLOW)
        ) u_chk (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_code       (w_code[g]),
            .o_illegal    (w_ill[g]),
            .o_seq_err    (w_seq[g]),
            .o_timing_err (w_tim[g]),
            .o_is_active  (w_act[g]),
            .o_phase_done (w_pd[g])
        );
    end

    always_comb begin
        w_nact = '0;
        w_npd  = '0;
        for (int i = 0; i < 4; i++) begin
            w_nact = w_nact + 3'(w_act[i]);
            w_npd  = w_npd + 3'(w_pd[i]);
        end
    end

    assign w_all_red  = (w_act == 4'b0000);
    assign w_conflict = (w_nact > 3'd1);
    // Counter equals MAX here, so this sample takes the run
    // past MAX; saturation above keeps it to once per run.
    assign w_stall    = r_vld && w_all_red &&
                        (r_red_cnt == RC_MAX);

    always_comb begin
        w_new_type = ERR_NONE;
        w_new_dir  = DIR_N;
        if (|w_ill) begin
            w_new_type = ERR_CODE;
            w_new_dir  = first_dir(w_ill);
        end else if (w_conflict) begin
            w_new_type = ERR_CONFLICT;
        end else if (|w_seq) begin
            w_new_type = ERR_SEQ;
            w_new_dir  = first_dir(w_seq);
        end else if (|w_tim) begin
            w_new_type = ERR_TIMING;
            w_new_dir  = first_dir(w_tim);
        end else if (w_stall) begin
            w_new_type = ERR_STALL;
        end
    end

    // A clear in the same cycle as a new error reopens the
    // capture so the new error is recorded.
    assign w_base   = clr_err ? ERR_NONE : r_first_type;
    assign w_pc_sum = {1'b0, r_pc} + (CNT_W+1)'(w_npd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld          <= 1'b0;
            r_red_cnt      <= '0;
            r_err_code     <= 1'b0;
            r_err_conflict <= 1'b0;
            r_err_seq      <= 1'b0;
            r_err_timing   <= 1'b0;
            r_err_stall    <= 1'b0;
            r_first_type   <= ERR_NONE;
            r_first_dir    <= DIR_N;
            r_act_vld      <= 1'b0;
            r_act_dir      <= DIR_N;
            r_pc           <= '0;
        end else begin
            r_vld <= 1'b1;
            if (r_vld && w_all_red) begin
                if (r_red_cnt != RC_SAT)
                    r_red_cnt <= r_red_cnt + RC_ONE;
            end else begin
                r_red_cnt <= '0;
            end

            r_err_code     <= (r_err_code && !clr_err) ||
                              (|w_ill);
            r_err_conflict <= (r_err_conflict && !clr_err) ||
                              w_conflict;
            r_err_seq      <= (r_err_seq && !clr_err) ||
                              (|w_seq);
            r_err_timing   <= (r_err_timing && !clr_err) ||
                              (|w_tim);
            r_err_stall    <= (r_err_stall && !clr_err) ||
                              w_stall;

            if (w_base == ERR_NONE) begin
                r_first_type <= w_new_type;
                r_first_dir  <= w_new_dir;
            end

            r_act_vld <= (w_nact == 3'd1);
            r_act_dir <= (w_nact == 3'd1) ? first_dir(w_act)
                                          : DIR_N;

            r_pc <= (w_pc_sum > PC_MAX) ? PC_MAX[CNT_W-1:0]
                                        : w_pc_sum[CNT_W-1:0];
        end
    end

    assign err_code       = r_err_code;
    assign err_conflict   = r_err_conflict;
    assign err_seq        = r_err_seq;
    assign err_timing     = r_err_timing;
    assign err_stall      = r_err_stall;
    assign first_err_type = r_first_type;
    assign first_err_dir  = r_first_dir;
    assign active_valid   = r_act_vld;
    assign active_dir     = r_act_dir;
    assign phase_count    = r_pc;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed scenarios plus a randomized
// controller, checked against a behavioural model every cycle.
module tb_traffic_light_monitor;

    localparam int MIN_Y = 3;
    localparam int MAX_Y = 8;
    localparam int MAX_R = 16;
    localparam int CW    = 8;

    localparam logic [3:0] R  = 4'b0001;
    localparam logic [3:0] Y  = 4'b0010;
    localparam logic [3:0] G  = 4'b0100;
    localparam logic [3:0] GA = 4'b1100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    north = R;
    logic [3:0]    east = R;
    logic [3:0]    south = R;
    logic [3:0]    west = R;
    logic          clr_err = 1'b0;
    logic          err_code;
    logic          err_conflict;
    logic          err_seq;
    logic          err_timing;
    logic          err_stall;
    logic [2:0]    first_err_type;
    logic [1:0]    first_err_dir;
    logic          active_valid;
    logic [1:0]    active_dir;
    logic [CW-1:0] phase_count;

    traffic_light_monitor #(
        .MIN_YELLOW  (MIN_Y),
        .MAX_YELLOW  (MAX_Y),
        .MAX_ALL_RED (MAX_R),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .north          (north),
        .east           (east),
        .south          (south),
        .west           (west),
        .clr_err        (clr_err),
        .err_code       (err_code),
        .err_conflict   (err_conflict),
        .err_seq        (err_seq),
        .err_timing     (err_timing),
        .err_stall      (err_stall),
        .first_err_type (first_err_type),
        .first_err_dir  (first_err_dir),
        .active_valid   (active_valid),
        .active_dir     (active_dir),
        .phase_count    (phase_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(string tag, int obs, int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Model: light kind 0 red, 1 yellow, 2 green.
    logic [3:0] m_cur [4];
    int         m_pk [4];
    int         m_yrun [4];
    int         m_rrun;
    bit         m_vld;
    bit         e_code, e_conf, e_seq, e_tim, e_stall;
    int         e_ftype, e_fdir;
    bit         e_av;
    int         e_ad;
    int         e_pc;

    function automatic int kind(logic [3:0] c);
        if (c == Y) return 1;
        if (c == G || c == GA) return 2;
        return 0;
    endfunction

    function automatic bit bad(logic [3:0] c);
        return !(c == R || c == Y || c == G || c == GA);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_cur[d]  = R;
            m_pk[d]   = 0;
            m_yrun[d] = 0;
        end
        m_rrun = 0;
        m_vld = 0;
        {e_code, e_conf, e_seq, e_tim, e_stall} = '0;
        e_ftype = 0;
        e_fdir = 0;
        e_av = 0;
        e_ad = 0;
        e_pc = 0;
    endtask

    // One clock edge: judge the cur sample against prev.
    task automatic model_edge(logic [3:0] n0, logic [3:0] n1,
                              logic [3:0] n2, logic [3:0] n3,
                              bit clr);
        int c, p, run, nact, adir, pd, ti, si, ii;
        bit st;
        nact = 0; adir = 0; pd = 0;
        ti = -1; si = -1; ii = -1;
        for (int d = 0; d < 4; d++) begin
            c = kind(m_cur[d]);
            p = m_pk[d];
            if (bad(m_cur[d]) && ii < 0) ii = d;
            if (!(p == c || (p == 0 && c == 2) ||
                  (p == 2 && c == 1) || (p == 1 && c == 0)))
                if (si < 0) si = d;
            run = (c == 1) ? ((p == 1) ? m_yrun[d] + 1 : 1) : 0;
            if ((p == 1 && c == 0 && m_yrun[d] < MIN_Y) ||
                run == MAX_Y + 1)
                if (ti < 0) ti = d;
            if (p == 1 && c == 0) pd++;
            if (c != 0) begin
                if (nact == 0) adir = d;
                nact++;
            end
            m_yrun[d] = run;
            m_pk[d] = c;
        end
        st = 0;
        if (m_vld && nact == 0) begin
            m_rrun++;
            st = (m_rrun == MAX_R + 1);
        end else begin
            m_rrun = 0;
        end
        e_code  = (e_code && !clr) || (ii >= 0);
        e_conf  = (e_conf && !clr) || (nact >= 2);
        e_seq   = (e_seq && !clr) || (si >= 0);
        e_tim   = (e_tim && !clr) || (ti >= 0);
        e_stall = (e_stall && !clr) || st;
        if (clr || e_ftype == 0) begin
            e_ftype = 0; e_fdir = 0;
            if (ii >= 0) begin e_ftype = 1; e_fdir = ii; end
            else if (nact >= 2) e_ftype = 2;
            else if (si >= 0) begin e_ftype = 3; e_fdir = si; end
            else if (ti >= 0) begin e_ftype = 4; e_fdir = ti; end
            else if (st) e_ftype = 5;
        end
        e_av = (nact == 1);
        e_ad = (nact == 1) ? adir : 0;
        e_pc = (e_pc + pd > 255) ? 255 : e_pc + pd;
        m_cur[0] = n0; m_cur[1] = n1;
        m_cur[2] = n2; m_cur[3] = n3;
        m_vld = 1;
    endtask

    task automatic compare_all();
        check("err_code", err_code, e_code);
        check("err_conflict", err_conflict, e_conf);
        check("err_seq", err_seq, e_seq);
        check("err_timing", err_timing, e_tim);
        check("err_stall", err_stall, e_stall);
        check("first_type", first_err_type, e_ftype);
        check("first_dir", first_err_dir, e_fdir);
        check("active_valid", active_valid, e_av);
        check("active_dir", active_dir, e_ad);
        check("phase_count", phase_count, e_pc);
    endtask

    task automatic step(logic [3:0] n, logic [3:0] e,
                        logic [3:0] s, logic [3:0] w, bit clr);
        @(negedge clk);
        compare_all();
        north = n; east = e; south = s; west = w;
        clr_err = clr;
        model_edge(n, e, s, w, clr);
    endtask

    task automatic one(int d, logic [3:0] code, bit clr = 0);
        logic [3:0] c [4];
        for (int i = 0; i < 4; i++) c[i] = R;
        c[d] = code;
        step(c[0], c[1], c[2], c[3], clr);
    endtask

    task automatic phase(int d, int g, int y);
        repeat (g) one(d, G);
        repeat (y) one(d, Y);
        one(d, R);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_pc", phase_count, 0);
        check("rst_flags", {err_code, err_conflict, err_seq,
                            err_timing, err_stall}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        north = R; east = R; south = R; west = R;
        clr_err = 1'b0;
        model_edge(R, R, R, R, 0);
    endtask

    initial begin
        logic [3:0] c [4];
        int rd, rs, rl, pc_save;
        bit clr;
        model_reset();
        do_reset();

        // Legal N then E phase.
        repeat (2) one(0, R);
        repeat (3) one(0, G);
        check("t_act_n_vld", active_valid, 1);
        check("t_act_n_dir", active_dir, 0);
        repeat (7) one(0, G);
        repeat (4) one(0, Y);
        one(0, R);
        repeat (4) one(1, G);
        check("t_act_e_dir", active_dir, 1);
        repeat (6) one(1, GA);
        repeat (4) one(1, Y);
        repeat (3) one(1, R);
        check("t_legal_pc", phase_count, 2);
        check("t_legal_type", first_err_type, 0);

        // Illegal west code.
        one(3, 4'b0011);
        repeat (3) one(0, R);
        check("t_ill_flag", err_code, 1);
        check("t_ill_type", first_err_type, 1);
        check("t_ill_dir", first_err_dir, 3);

        // Conflict and bad sequence in one sample.
        one(0, R, 1);
        step(G, Y, R, R, 0);
        repeat (3) step(G, R, R, R, 0);
        check("t_conf_flag", err_conflict, 1);
        check("t_conf_seq", err_seq, 1);
        check("t_conf_type", first_err_type, 2);
        repeat (3) one(0, Y);
        repeat (3) one(0, R);

        // Short yellow on N.
        one(0, R, 1);
        phase(0, 3, 2);
        repeat (2) one(0, R);
        check("t_short_flag", err_timing, 1);
        check("t_short_type", first_err_type, 4);
        check("t_short_dir", first_err_dir, 0);

        // Long yellow on S.
        one(0, R, 1);
        repeat (3) one(2, G);
        repeat (8) one(2, Y);
        one(2, Y);
        one(2, Y);
        check("t_long_pre", err_timing, 0);
        one(2, R);
        one(2, R);
        check("t_long_flag", err_timing, 1);
        check("t_long_dir", first_err_dir, 2);

        // All-red stall, then clear.
        one(0, R, 1);
        repeat (20) one(0, R);
        check("t_stall_flag", err_stall, 1);
        check("t_stall_type", first_err_type, 5);
        pc_save = phase_count;
        one(0, R, 1);
        repeat (2) one(0, R);
        check("t_clr_flags", {err_code, err_conflict, err_seq,
                              err_timing, err_stall}, 0);
        check("t_clr_pc", phase_count, pc_save);

        // Reset while N is yellow.
        repeat (3) one(0, G);
        repeat (2) one(0, Y);
        do_reset();

        // Randomized controller with occasional faults.
        rd = 0; rs = 2; rl = 0;
        repeat (2000) begin
            while (rl == 0) begin
                rs = (rs + 1) % 3;
                if (rs == 0) rd = $urandom_range(0, 3);
                rl = (rs == 0) ? $urandom_range(1, 6) :
                     (rs == 1) ? $urandom_range(1, 10) :
                                 $urandom_range(0, 20);
            end
            for (int i = 0; i < 4; i++) c[i] = R;
            if (rs == 0)
                c[rd] = ($urandom_range(0, 1) != 0) ? GA : G;
            else if (rs == 1)
                c[rd] = Y;
            rl--;
            if ($urandom_range(0, 39) == 0)
                c[$urandom_range(0, 3)] =
                    4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 49) == 0);
            step(c[0], c[1], c[2], c[3], clr);
        end

        // Saturation of phase_count.
        repeat (3) one(0, R, 1);
        repeat (260) phase($urandom_range(0, 3), 1, 3);
        repeat (2) one(0, R);
        check("t_sat_pc", phase_count, 255);

        @(negedge clk);
        compare_all();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
